// File: rtl/imm_decode_if.sv
// imm_decode_if: upstream/downstream handshake bundle for imm_decode_stage.
interface imm_decode_if #(parameter int PC_WIDTH = 32);
  localparam int IMM_TYPE_WIDTH = 3;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [31:0] in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_instr;
  logic [PC_WIDTH-1:0] out_pc;
  logic [31:0] out_imm;
  logic [IMM_TYPE_WIDTH-1:0] out_imm_sel;
  logic [PC_WIDTH-1:0] out_target;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_sel, out_target
  );
  modport slave (
    input flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_sel, out_target
  );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I immediate decode into a two-entry skid buffer; IMM_DECODE_TARGET_EN adds a per-entry pc+imm target.
module imm_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  imm_decode_if.slave bus
);
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;
  typedef struct packed {
    logic [31:0] instr;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0] imm;
    logic [2:0] sel;
    logic [PC_WIDTH-1:0] target;
  } entry_t;
  logic [31:0] i;
  logic [6:0] op;
  logic [2:0] sel;
  logic [31:0] imm;
  logic [PC_WIDTH-1:0] tgt;
  entry_t nw, m, k, m_n, k_n;
  logic m_v, k_v, m_v_n, k_v_n, acc, rel;
  assign i = bus.in_instr;
  assign op = i[6:0];
  assign sel = (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011) ? IMM_I :
               op == 7'b0100011 ? IMM_S :
               op == 7'b1100011 ? IMM_B :
               (op == 7'b0110111 || op == 7'b0010111) ? IMM_U :
               op == 7'b1101111 ? IMM_J : 3'd0;
  assign imm = sel == IMM_I ? {{20{i[31]}}, i[31:20]} :
               sel == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               sel == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
               sel == IMM_U ? {i[31:12], 12'b0} :
               sel == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'd0;
`ifdef IMM_DECODE_TARGET_EN
  assign tgt = bus.in_pc + PC_WIDTH'(signed'(imm));
`else
  assign tgt = '0;
`endif
  assign nw = '{instr: i, pc: bus.in_pc, imm: imm, sel: sel, target: tgt};
  assign acc = bus.in_valid && bus.in_ready;
  assign rel = m_v && bus.out_ready;
  // in_ready can only be high with K empty, so K never refills in the cycle it drains
  always_comb begin
    m_n = m;
    k_n = k;
    m_v_n = m_v;
    k_v_n = k_v;
    if (rel && k_v) begin
      m_n = k;
      k_v_n = 1'b0;
    end else if (acc && (!m_v || rel)) begin
      m_n = nw;
      m_v_n = 1'b1;
    end else if (acc) begin
      k_n = nw;
      k_v_n = 1'b1;
    end else if (rel) m_v_n = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      k <= '0;
      m_v <= 1'b0;
      k_v <= 1'b0;
    end else if (bus.flush) begin
      m_v <= 1'b0;
      k_v <= 1'b0;
    end else begin
      m <= m_n;
      k <= k_n;
      m_v <= m_v_n;
      k_v <= k_v_n;
    end
  end
  assign bus.in_ready = !k_v;
  assign bus.out_valid = m_v;
  assign bus.out_instr = m.instr;
  assign bus.out_pc = m.pc;
  assign bus.out_imm = m.imm;
  assign bus.out_imm_sel = m.sel;
  assign bus.out_target = m.target;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: scoreboard bench for imm_decode_stage (honours IMM_DECODE_TARGET_EN).
module tb_imm_decode_stage;
`ifdef IMM_DECODE_TARGET_EN
  localparam bit TGT = 1'b1;
`else
  localparam bit TGT = 1'b0;
`endif
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] sel;
    logic [31:0] tgt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0;
  int errs = 0;
  int rel_cnt = 0;
  exp_t q[$];
  exp_t vec[9];
  imm_decode_if #(.PC_WIDTH(32)) bus ();
  imm_decode_stage #(.PC_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] sel, input logic [31:0] tgt);
    exp_t e;
    e.instr = ins;
    e.pc = pc;
    e.imm = imm;
    e.sel = sel;
    e.tgt = TGT ? tgt : 32'd0;
    return e;
  endfunction
  task automatic send(input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_instr = e.instr;
    bus.in_pc = e.pc;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (t == 49) begin
        nchk++;
        errs++;
        $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
        rel_cnt++;
        if (q.size() == 0) begin
          nchk++;
          errs++;
          $display("FAIL unexpected_output: got instr %h expected none", bus.out_instr);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instr", bus.out_instr, e.instr);
          chk("pc", bus.out_pc, e.pc);
          chk("imm", bus.out_imm, e.imm);
          chk("sel", 32'(bus.out_imm_sel), e.sel);
          chk("target", bus.out_target, e.tgt);
        end
      end
    end
  end
  initial begin
    int r0;
    vec[0] = mk(32'hFFF00093, 32'h000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
    vec[1] = mk(32'h00112623, 32'h004, 32'h0000000C, 2, 32'h00000010);
    vec[2] = mk(32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 3, 32'h000001FC);
    vec[3] = mk(32'h123450B7, 32'h008, 32'h12345000, 4, 32'h12345008);
    vec[4] = mk(32'h008000EF, 32'h100, 32'h00000008, 5, 32'h00000108);
    vec[5] = mk(32'h00208033, 32'h010, 32'h00000000, 0, 32'h00000010);
    vec[6] = mk(32'h30002073, 32'h014, 32'h00000300, 1, 32'h00000314);
    vec[7] = mk(32'hFE112E23, 32'h018, 32'hFFFFFFFC, 2, 32'h00000014);
    vec[8] = mk(32'h000080E7, 32'h01C, 32'h00000000, 1, 32'h0000001C);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_imm", bus.out_imm, 0);
    chk("rst_sel", 32'(bus.out_imm_sel), 0);
    chk("rst_target", bus.out_target, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(vec[0]);
    chk("latency_valid", 32'(bus.out_valid), 1);
    chk("latency_imm", bus.out_imm, 32'hFFFFFFFF);
    for (int n = 1; n < 9; n++) send(vec[n]);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_drained", q.size(), 0);
    bus.out_ready = 1'b0;
    send(vec[1]);
    send(vec[2]);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    chk("bp_head", bus.out_instr, vec[1].instr);
    r0 = rel_cnt;
    fork
      send(vec[3]);
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("bp_stable", bus.out_instr, vec[1].instr);
        bus.out_ready = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    chk("bp_releases", rel_cnt - r0, 3);
    chk("bp_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    send(vec[4]);
    send(vec[5]);
    bus.in_valid = 1'b1;
    bus.in_instr = vec[6].instr;
    bus.in_pc = vec[6].pc;
    bus.flush = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_output", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    send(vec[7]);
    send(vec[8]);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    chk("arst_instr", bus.out_instr, 0);
    chk("arst_pc", bus.out_pc, 0);
    chk("arst_imm", bus.out_imm, 0);
    chk("arst_sel", 32'(bus.out_imm_sel), 0);
    chk("arst_target", bus.out_target, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(vec[4]);
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    chk("post_rst_instr", bus.out_instr, vec[4].instr);
    for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
